// File: rtl/llm_int8_matmul_sched.sv
// Shares one matmul engine between the outlier and quantized halves of the mixed-precision
// int8 decomposition: buffers a tile, replays it as a large pass then a small pass, and sums the two results.
module llm_int8_matmul_sched #(
    parameter int IN_WIDTH           = 16,
    parameter int IN_SIZE            = 4,
    parameter int IN_PARALLELISM     = 20,
    parameter int WEIGHT_WIDTH       = IN_WIDTH,
    parameter int WEIGHT_SIZE        = IN_SIZE,
    parameter int WEIGHT_PARALLELISM = 1,
    parameter int OUT_WIDTH          = 2*IN_WIDTH+IN_SIZE,
    parameter int IN_DEPTH           = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [IN_WIDTH-1:0]     data_in_large [IN_PARALLELISM*IN_SIZE],
    input  logic [IN_WIDTH-1:0]     data_in_small [IN_PARALLELISM*IN_SIZE],
    input  logic                    data_in_valid,
    output logic                    data_in_ready,
    input  logic [WEIGHT_WIDTH-1:0] weight [WEIGHT_SIZE*WEIGHT_PARALLELISM],
    input  logic                    weight_valid,
    output logic                    weight_ready,
    output logic [IN_WIDTH-1:0]     mm_data [IN_PARALLELISM*IN_SIZE],
    output logic                    mm_data_valid,
    input  logic                    mm_data_ready,
    output logic [WEIGHT_WIDTH-1:0] mm_weight [WEIGHT_SIZE*WEIGHT_PARALLELISM],
    output logic                    mm_weight_valid,
    input  logic                    mm_weight_ready,
    input  logic [OUT_WIDTH-1:0]    mm_result [IN_PARALLELISM*WEIGHT_PARALLELISM],
    input  logic                    mm_result_valid,
    output logic                    mm_result_ready,
    output logic [OUT_WIDTH-1:0]    data_out [IN_PARALLELISM*WEIGHT_PARALLELISM],
    output logic                    data_out_valid,
    input  logic                    data_out_ready,
    output logic                    busy
);
    localparam int DN   = IN_PARALLELISM*IN_SIZE;
    localparam int WN   = WEIGHT_SIZE*WEIGHT_PARALLELISM;
    localparam int NOUT = IN_PARALLELISM*WEIGHT_PARALLELISM;
    localparam int IDXW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(IN_DEPTH-1);

    localparam logic [1:0] FILL    = 2'd0;
    localparam logic [1:0] ISSUE_L = 2'd1;
    localparam logic [1:0] ISSUE_S = 2'd2;

    logic [1:0]      state;
    logic [IDXW-1:0] idx;
    logic            w_sent, d_sent, rph;

    logic [IN_WIDTH-1:0]     lbuf [IN_DEPTH][DN];
    logic [IN_WIDTH-1:0]     sbuf [IN_DEPTH][DN];
    logic [WEIGHT_WIDTH-1:0] wbuf [IN_DEPTH][WN];
    logic [OUT_WIDTH-1:0]    acc  [NOUT];

    logic filling, issuing, fill_fire, w_fire, d_fire, beat_done, res_fire;

    assign filling   = (state == FILL);
    assign issuing   = (state == ISSUE_L) || (state == ISSUE_S);
    assign data_in_ready = filling && weight_valid;
    assign weight_ready  = filling && data_in_valid;
    assign fill_fire = filling && data_in_valid && weight_valid;

    assign mm_weight_valid = issuing && !w_sent;
    assign mm_data_valid   = issuing && !d_sent;
    assign w_fire    = mm_weight_valid && mm_weight_ready;
    assign d_fire    = mm_data_valid && mm_data_ready;
    // Channels may accept a beat in different cycles; the sent flags keep them paired.
    assign beat_done = issuing && (w_fire || w_sent) && (d_fire || d_sent);

    assign mm_result_ready = rph ? (!data_out_valid || data_out_ready) : 1'b1;
    assign res_fire = mm_result_valid && mm_result_ready;
    assign busy     = !filling || rph;

    always_comb begin
        for (int i = 0; i < WN; i++) mm_weight[i] = wbuf[idx][i];
        for (int i = 0; i < DN; i++) mm_data[i] = (state == ISSUE_S) ? sbuf[idx][i] : lbuf[idx][i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FILL;
            idx    <= '0;
            w_sent <= 1'b0;
            d_sent <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (fill_fire) begin
                        if (idx == LAST) begin
                            idx   <= '0;
                            state <= ISSUE_L;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ISSUE_L, ISSUE_S: begin
                    if (beat_done) begin
                        w_sent <= 1'b0;
                        d_sent <= 1'b0;
                        if (idx == LAST) begin
                            idx   <= '0;
                            state <= (state == ISSUE_L) ? ISSUE_S : FILL;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        if (w_fire) w_sent <= 1'b1;
                        if (d_fire) d_sent <= 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // Tile storage needs no reset: idx returning to 0 discards any partial tile.
    always_ff @(posedge clk) begin
        if (fill_fire) begin
            for (int i = 0; i < DN; i++) begin
                lbuf[idx][i] <= data_in_large[i];
                sbuf[idx][i] <= data_in_small[i];
            end
            for (int i = 0; i < WN; i++) wbuf[idx][i] <= weight[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rph            <= 1'b0;
            data_out_valid <= 1'b0;
            for (int i = 0; i < NOUT; i++) begin
                acc[i]      <= '0;
                data_out[i] <= '0;
            end
        end else begin
            if (res_fire) begin
                if (!rph) begin
                    for (int i = 0; i < NOUT; i++) acc[i] <= mm_result[i];
                    rph <= 1'b1;
                end else begin
                    for (int i = 0; i < NOUT; i++) data_out[i] <= acc[i] + mm_result[i];
                    rph <= 1'b0;
                end
            end
            if (res_fire && rph)
                data_out_valid <= 1'b1;
            else if (data_out_ready)
                data_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_llm_int8_matmul_sched.sv
// Bench for llm_int8_matmul_sched: a behavioural dot-product engine closes the loop and a
// tile-level reference predicts the replay order and the summed output.
module tb_llm_int8_matmul_sched;
    localparam int IW = 16;
    localparam int IS = 2;
    localparam int IP = 1;
    localparam int WP = 1;
    localparam int D  = 2;
    localparam int OW = 2*IW+IS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [IW-1:0] data_in_large [2];
    logic [IW-1:0] data_in_small [2];
    logic          data_in_valid, data_in_ready;
    logic [IW-1:0] weight [2];
    logic          weight_valid, weight_ready;
    logic [IW-1:0] mm_data [2];
    logic          mm_data_valid, mm_data_ready;
    logic [IW-1:0] mm_weight [2];
    logic          mm_weight_valid, mm_weight_ready;
    logic [OW-1:0] mm_result [1];
    logic          mm_result_valid, mm_result_ready;
    logic [OW-1:0] data_out [1];
    logic          data_out_valid, data_out_ready, busy;

    logic rand_mode;
    logic dir_dr, dir_wr, dir_or;
    logic rnd_dr, rnd_wr, rnd_or;
    assign mm_data_ready   = rand_mode ? rnd_dr : dir_dr;
    assign mm_weight_ready = rand_mode ? rnd_wr : dir_wr;
    assign data_out_ready  = rand_mode ? rnd_or : dir_or;

    llm_int8_matmul_sched #(
        .IN_WIDTH(IW), .IN_SIZE(IS), .IN_PARALLELISM(IP), .WEIGHT_WIDTH(IW),
        .WEIGHT_SIZE(IS), .WEIGHT_PARALLELISM(WP), .OUT_WIDTH(OW), .IN_DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst),
        .data_in_large(data_in_large), .data_in_small(data_in_small),
        .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .weight(weight), .weight_valid(weight_valid), .weight_ready(weight_ready),
        .mm_data(mm_data), .mm_data_valid(mm_data_valid), .mm_data_ready(mm_data_ready),
        .mm_weight(mm_weight), .mm_weight_valid(mm_weight_valid), .mm_weight_ready(mm_weight_ready),
        .mm_result(mm_result), .mm_result_valid(mm_result_valid), .mm_result_ready(mm_result_ready),
        .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
        .busy(busy)
    );

    // Narrow-output instance whose result port is driven directly to exercise wrap-around.
    logic [IW-1:0] o_dl [2];
    logic [IW-1:0] o_ds [2];
    logic [IW-1:0] o_w [2];
    logic [IW-1:0] o_mmd [2];
    logic [IW-1:0] o_mmw [2];
    logic [7:0]    o_res [1];
    logic [7:0]    o_dout [1];
    logic o_dir, o_wr, o_mmdv, o_mmwv, o_res_valid, o_res_ready, o_dout_valid, o_busy;

    llm_int8_matmul_sched #(
        .IN_WIDTH(IW), .IN_SIZE(IS), .IN_PARALLELISM(IP), .WEIGHT_WIDTH(IW),
        .WEIGHT_SIZE(IS), .WEIGHT_PARALLELISM(WP), .OUT_WIDTH(8), .IN_DEPTH(D)
    ) dut_ovf (
        .clk(clk), .rst(rst),
        .data_in_large(o_dl), .data_in_small(o_ds),
        .data_in_valid(1'b0), .data_in_ready(o_dir),
        .weight(o_w), .weight_valid(1'b0), .weight_ready(o_wr),
        .mm_data(o_mmd), .mm_data_valid(o_mmdv), .mm_data_ready(1'b1),
        .mm_weight(o_mmw), .mm_weight_valid(o_mmwv), .mm_weight_ready(1'b1),
        .mm_result(o_res), .mm_result_valid(o_res_valid), .mm_result_ready(o_res_ready),
        .data_out(o_dout), .data_out_valid(o_dout_valid), .data_out_ready(1'b1),
        .busy(o_busy)
    );

    // Behavioural engine: pairs the k-th data beat with the k-th weight beat, sums D beats.
    logic [31:0]   dq [$];
    logic [31:0]   wq [$];
    logic [31:0]   data_log [$];
    logic [OW-1:0] rq [$];
    int            res_fires = 0;
    longint unsigned eng_sum;
    logic [31:0]   eng_d, eng_w;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dq.delete(); wq.delete(); rq.delete(); data_log.delete();
            mm_result_valid <= 1'b0;
            mm_result[0]    <= '0;
        end else begin
            if (mm_result_valid && mm_result_ready) begin
                void'(rq.pop_front());
                res_fires++;
            end
            if (mm_data_valid && mm_data_ready) begin
                dq.push_back({mm_data[1], mm_data[0]});
                data_log.push_back({mm_data[1], mm_data[0]});
            end
            if (mm_weight_valid && mm_weight_ready)
                wq.push_back({mm_weight[1], mm_weight[0]});
            while (dq.size() >= D && wq.size() >= D) begin
                eng_sum = 0;
                for (int b = 0; b < D; b++) begin
                    eng_d = dq.pop_front();
                    eng_w = wq.pop_front();
                    eng_sum += 64'(eng_d[15:0]) * 64'(eng_w[15:0]) + 64'(eng_d[31:16]) * 64'(eng_w[31:16]);
                end
                rq.push_back(OW'(eng_sum));
            end
            mm_result_valid <= (rq.size() > 0);
            if (rq.size() > 0) mm_result[0] <= rq[0];
        end
    end

    logic [OW-1:0] out_q [$];
    always @(posedge clk)
        if (!rst && data_out_valid && data_out_ready) out_q.push_back(data_out[0]);

    initial begin
        rnd_dr = 1'b1; rnd_wr = 1'b1; rnd_or = 1'b1;
        forever begin
            @(negedge clk);
            rnd_dr = ($urandom_range(0, 3) != 0);
            rnd_wr = ($urandom_range(0, 3) != 0);
            rnd_or = ($urandom_range(0, 2) != 0);
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Current tile: beats packed as {element1, element0}.
    logic [31:0]   tl [D];
    logic [31:0]   ts [D];
    logic [31:0]   tw [D];
    logic [OW-1:0] exp_sum [$];
    logic [31:0]   exp_log [$];

    function automatic logic [OW-1:0] refSum();
        longint unsigned s = 0;
        for (int b = 0; b < D; b++)
            for (int k = 0; k < IS; k++)
                s += (64'(tl[b][16*k +: 16]) + 64'(ts[b][16*k +: 16])) * 64'(tw[b][16*k +: 16]);
        return OW'(s);
    endfunction

    task automatic randomTile();
        for (int b = 0; b < D; b++) begin
            tl[b] = $urandom; ts[b] = $urandom; tw[b] = $urandom;
        end
    endtask

    task automatic applyStimulus(input int max_gap);
        int waited;
        exp_sum.push_back(refSum());
        for (int b = 0; b < D; b++) exp_log.push_back(tl[b]);
        for (int b = 0; b < D; b++) exp_log.push_back(ts[b]);
        for (int b = 0; b < D; b++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(negedge clk);
                data_in_valid = 1'b0; weight_valid = 1'b0;
            end
            @(negedge clk);
            data_in_large[0] = tl[b][15:0]; data_in_large[1] = tl[b][31:16];
            data_in_small[0] = ts[b][15:0]; data_in_small[1] = ts[b][31:16];
            weight[0] = tw[b][15:0];        weight[1] = tw[b][31:16];
            data_in_valid = 1'b1; weight_valid = 1'b1;
            #1;
            waited = 0;
            while (!(data_in_ready && weight_ready) && waited < 300) begin
                @(negedge clk); #1;
                waited++;
            end
            check("fill_accept", data_in_ready && weight_ready, 1);
            @(posedge clk);
        end
        @(negedge clk);
        data_in_valid = 1'b0; weight_valid = 1'b0;
    endtask

    task automatic checkOutput(output logic [OW-1:0] got);
        int waited = 0;
        while (out_q.size() == 0 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        check("out_arrived", out_q.size() > 0, 1);
        got = '0;
        if (out_q.size() > 0 && exp_sum.size() > 0) begin
            got = out_q.pop_front();
            check("data_out_sum", got, exp_sum.pop_front());
        end
    endtask

    task automatic checkBeats();
        while (data_log.size() > 0 && exp_log.size() > 0)
            check("mm_data_seq", data_log.pop_front(), exp_log.pop_front());
    endtask

    task automatic directedTile();
        tl[0] = {16'd2, 16'd1};  tl[1] = {16'd4, 16'd3};
        ts[0] = {16'd0, 16'd10}; ts[1] = {16'd10, 16'd0};
        tw[0] = {16'd1, 16'd1};  tw[1] = {16'd2, 16'd2};
    endtask

    logic [OW-1:0] got;
    int            n0, r0, waited;
    logic [7:0]    a8, b8;

    initial begin
        rst = 1'b1; rand_mode = 1'b0;
        dir_dr = 1'b1; dir_wr = 1'b1; dir_or = 1'b1;
        data_in_valid = 1'b0; weight_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            data_in_large[i] = '0; data_in_small[i] = '0; weight[i] = '0;
            o_dl[i] = '0; o_ds[i] = '0; o_w[i] = '0;
        end
        o_res[0] = '0; o_res_valid = 1'b0;

        // Reset values, and readies mirroring the opposite valid.
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", data_out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_mm_data_valid", mm_data_valid, 0);
        check("rst_mm_weight_valid", mm_weight_valid, 0);
        check("rst_result_ready", mm_result_ready, 1);
        check("rst_data_out", data_out[0], 0);
        check("rst_data_in_ready", data_in_ready, 0);
        @(negedge clk);
        rst = 1'b0;

        // Weight without data must not fill.
        weight_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            check("wonly_weight_ready", weight_ready, 0);
            check("wonly_data_in_ready", data_in_ready, 1);
            check("wonly_no_issue", mm_data_valid, 0);
        end
        weight_valid = 1'b0;

        $display("[TB] directed tile");
        directedTile();
        applyStimulus(0);
        checkOutput(got);
        check("directed_47", got, 47);
        checkBeats();

        $display("[TB] weight channel back-pressure");
        dir_wr = 1'b0;
        directedTile();
        applyStimulus(0);
        n0 = data_log.size();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            check("bp_data_sent_once", data_log.size(), n0 + 1);
            check("bp_data_valid_low", mm_data_valid, 0);
            check("bp_weight_held", {mm_weight[1], mm_weight[0]}, tw[0]);
        end
        dir_wr = 1'b1;
        checkOutput(got);
        check("bp_result_47", got, 47);
        checkBeats();

        $display("[TB] output stall across two tiles");
        dir_or = 1'b0;
        directedTile();
        applyStimulus(0);
        randomTile();
        applyStimulus(0);
        repeat (40) @(negedge clk);
        #1;
        check("stall_valid", data_out_valid, 1);
        check("stall_hold", data_out[0], 47);
        check("stall_rph1_ready", mm_result_ready, 0);
        check("stall_pending", mm_result_valid, 1);
        dir_or = 1'b1;
        checkOutput(got);
        checkOutput(got);
        checkBeats();

        $display("[TB] reset with large result latched");
        randomTile();
        r0 = res_fires;
        applyStimulus(0);
        waited = 0;
        while (res_fires == r0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("mid_first_fire", res_fires, r0 + 1);
        check("mid_busy_rph", busy, 1);
        rst = 1'b1;
        #1;
        void'(exp_sum.pop_back());
        exp_log.delete();
        check("mid_rst_valid", data_out_valid, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("mid_no_partial", out_q.size(), 0);
        randomTile();
        applyStimulus(0);
        checkOutput(got);
        checkBeats();

        $display("[TB] randomized tiles with random back-pressure");
        rand_mode = 1'b1;
        for (int t = 0; t < 8; t++) begin
            randomTile();
            applyStimulus(2);
        end
        for (int t = 0; t < 8; t++) checkOutput(got);
        rand_mode = 1'b0;
        repeat (5) @(negedge clk);
        checkBeats();
        check("beat_count_exp", exp_log.size(), 0);
        check("beat_count_obs", data_log.size(), 0);
        check("no_extra_out", out_q.size(), 0);

        $display("[TB] OUT_WIDTH=8 wrap-around");
        @(negedge clk);
        o_res[0] = 8'd200; o_res_valid = 1'b1;
        @(negedge clk);
        o_res[0] = 8'd100;
        @(negedge clk);
        o_res_valid = 1'b0;
        #1;
        check("ovf_valid", o_dout_valid, 1);
        check("ovf_44", o_dout[0], 44);
        for (int t = 0; t < 4; t++) begin
            a8 = 8'($urandom); b8 = 8'($urandom);
            @(negedge clk);
            o_res[0] = a8; o_res_valid = 1'b1;
            @(negedge clk);
            o_res[0] = b8;
            @(negedge clk);
            o_res_valid = 1'b0;
            #1;
            check("ovf_rand", o_dout[0], (int'(a8) + int'(b8)) % 256);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
